matmul_control_fsm: RTL and testbench

//   Sequencing FSM of the UART matrix-multiply engine. Accepts a size byte N, then N*N bytes of

---
 rtl/matmul_control_fsm_if.sv | 27 ++
 rtl/matmul_control_fsm.sv | 122 ++++++++++++
 tb/tb_matmul_control_fsm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_control_fsm_if.sv
// Handshake bundle between the matrix-multiply sequencer and its UART, memory and multiplier neighbours.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface matmul_control_fsm_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       mult_done;
  logic       rx_enable;
  logic       tx_start;
  logic       mult_start;
  logic [2:0] current_state;
  logic [3:0] matrix_size;
  logic       read_enable_a;
  logic       read_enable_b;

  modport master (
    input  rx_valid, rx_data, tx_busy, mult_done,
    output rx_enable, tx_start, mult_start, current_state, matrix_size,
           read_enable_a, read_enable_b
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, mult_done,
    input  rx_enable, tx_start, mult_start, current_state, matrix_size,
           read_enable_a, read_enable_b
  );
endinterface

// File: rtl/matmul_control_fsm.sv
// Sequencer for the UART matrix-multiply engine: takes N, then A and B element bytes,
// runs the multiplier, and paces the transmitter through the 2*N*N result bytes.
module matmul_control_fsm #(
  parameter int MAX_N = 10
) (
  input  logic                 bclk,
  input  logic                 rst,
  matmul_control_fsm_if.master ctrl
);

  localparam logic [2:0] S_IDLE      = 3'b000;
  localparam logic [2:0] S_RX_SIZE   = 3'b001;
  localparam logic [2:0] S_RX_A      = 3'b010;
  localparam logic [2:0] S_RX_B      = 3'b011;
  localparam logic [2:0] S_COMPUTE   = 3'b100;
  localparam logic [2:0] S_SEND      = 3'b101;

  logic [2:0] state_q, state_d;
  logic [3:0] size_q, size_d;
  logic [6:0] elem_q, elem_d;
  logic [7:0] byte_q, byte_d;
  logic       tx_start_q, tx_start_d;
  logic       wait_q, wait_d;

  logic [7:0] elem_total;
  logic [8:0] result_bytes;
  logic       size_ok;
  logic       last_elem;
  logic       bytes_left;
  logic       tx_fire;

  // Element count is derived from the latched size so a late rx_data change cannot disturb it.
  assign elem_total   = {4'd0, size_q} * {4'd0, size_q};
  assign result_bytes = {elem_total, 1'b0};
  assign size_ok      = (ctrl.rx_data >= 8'd1) && (ctrl.rx_data <= 8'(MAX_N));
  assign last_elem    = ({1'b0, elem_q} + 8'd1) == elem_total;
  assign bytes_left   = {1'b0, byte_q} < result_bytes;
  assign tx_fire      = (state_q == S_SEND) && !ctrl.tx_busy && !wait_q && bytes_left;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    elem_d     = elem_q;
    byte_d     = byte_q;
    tx_start_d = 1'b0;
    wait_d     = wait_q && !ctrl.tx_busy;
    case (state_q)
      S_IDLE: state_d = S_RX_SIZE;
      S_RX_SIZE: begin
        if (ctrl.rx_valid && size_ok) begin
          size_d  = ctrl.rx_data[3:0];
          elem_d  = 7'd0;
          state_d = S_RX_A;
        end
      end
      S_RX_A: begin
        if (ctrl.rx_valid) begin
          if (last_elem) begin
            elem_d  = 7'd0;
            state_d = S_RX_B;
          end else begin
            elem_d = elem_q + 7'd1;
          end
        end
      end
      S_RX_B: begin
        if (ctrl.rx_valid) begin
          if (last_elem) begin
            elem_d  = 7'd0;
            state_d = S_COMPUTE;
          end else begin
            elem_d = elem_q + 7'd1;
          end
        end
      end
      S_COMPUTE: begin
        if (ctrl.mult_done) begin
          byte_d  = 8'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // One pulse per byte; the wait flag holds off the next until busy has risen and fallen.
        if (tx_fire) begin
          tx_start_d = 1'b1;
          byte_d     = byte_q + 8'd1;
          wait_d     = 1'b1;
        end else if (!bytes_left && !wait_q && !ctrl.tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      size_q     <= 4'd0;
      elem_q     <= 7'd0;
      byte_q     <= 8'd0;
      tx_start_q <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      elem_q     <= elem_d;
      byte_q     <= byte_d;
      tx_start_q <= tx_start_d;
      wait_q     <= wait_d;
    end
  end

  assign ctrl.current_state = state_q;
  assign ctrl.matrix_size   = size_q;
  assign ctrl.tx_start      = tx_start_q;
  assign ctrl.rx_enable     = (state_q == S_RX_SIZE) || (state_q == S_RX_A) || (state_q == S_RX_B);
  assign ctrl.mult_start    = (state_q == S_COMPUTE);
  assign ctrl.read_enable_a = (state_q == S_COMPUTE);
  assign ctrl.read_enable_b = (state_q == S_COMPUTE);

endmodule

// File: tb/tb_matmul_control_fsm.sv
// Randomized scoreboard bench for matmul_control_fsm: every state change and tx_start pulse
// is matched against an expected-event queue filled by the stimulus process.
module tb_matmul_control_fsm;
  logic bclk = 1'b0;
  logic rst;

  matmul_control_fsm_if bus();

  matmul_control_fsm #(.MAX_N(10)) dut (
    .bclk (bclk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 bclk = ~bclk;

  typedef struct packed {
    logic       tx;
    logic [2:0] st;
    logic [3:0] sz;
    logic       rxe;
    logic       ms;
    logic       rea;
    logic       reb;
    logic       busy;
  } ev_t;

  ev_t expq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  bit  long_once = 1'b0;

  // Expected observable picture for a state (or a pulse while sending), straight from the output rules.
  function automatic ev_t mk(input bit tx, input logic [2:0] st, input int sz);
    ev_t e;
    e.tx   = tx;
    e.st   = st;
    e.sz   = 4'(sz);
    e.rxe  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    e.ms   = (st == 3'd4);
    e.rea  = (st == 3'd4);
    e.reb  = (st == 3'd4);
    e.busy = 1'b0;
    return e;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string nm);
    int i;
    i = 0;
    while (bus.current_state !== s && i < limit) begin
      tick();
      i++;
    end
    if (bus.current_state !== s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, state %0d expected %0d", nm, bus.current_state, s);
      summary_and_finish();
    end
  endtask

  task automatic push_tail(input int n);
    expq.push_back(mk(1'b0, 3'd5, n));
    for (int k = 0; k < 2 * n * n; k++) expq.push_back(mk(1'b1, 3'd5, n));
    expq.push_back(mk(1'b0, 3'd0, n));
    expq.push_back(mk(1'b0, 3'd1, n));
  endtask

  task automatic send_size_and_a(input int n);
    logic [7:0] bad;
    send_byte(8'h00); gap();
    send_byte(8'h0B); gap();
    bad = 8'($urandom_range(11, 255));
    send_byte(bad); gap();
    check("size_reject_state", int'(bus.current_state), 1);
    expq.push_back(mk(1'b0, 3'd2, n));
    send_byte(8'(n));
    check("size_latch", int'(bus.matrix_size), n);
    for (int i = 0; i < n * n; i++) begin
      gap();
      if (i == n * n - 1) expq.push_back(mk(1'b0, 3'd3, n));
      send_byte(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic run_txn(input int n, input bit early, input bit long_hold);
    send_size_and_a(n);
    for (int i = 0; i < n * n; i++) begin
      gap();
      if (i == n * n - 1) begin
        expq.push_back(mk(1'b0, 3'd4, n));
        if (early) begin
          push_tail(n);
          long_once     = long_hold;
          bus.mult_done = 1'b1;
        end
      end
      send_byte(8'($urandom_range(0, 255)));
    end
    if (early) begin
      check("compute_entry", int'(bus.current_state), 4);
      tick();
      check("early_done_advance", int'(bus.current_state), 5);
      bus.mult_done = 1'b0;
    end else begin
      wait_state(3'd4, 5, "enter_compute");
      send_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 4)) tick();
      check("compute_hold", int'(bus.current_state), 4);
      check("mult_start_high", int'(bus.mult_start), 1);
      push_tail(n);
      long_once     = long_hold;
      bus.mult_done = 1'b1;
      tick();
      bus.mult_done = 1'b0;
    end
    wait_state(3'd1, 2 * n * n * 70 + 100, "txn_done");
  endtask

  // Transmitter model: busy rises the cycle after each pulse and lasts a random time.
  initial begin
    int len;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge bclk);
      if (bus.tx_start === 1'b1) begin
        len       = long_once ? 50 : int'($urandom_range(1, 10));
        long_once = 1'b0;
        @(posedge bclk);
        #1 bus.tx_busy = 1'b1;
        repeat (len) tick();
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every state change or tx_start pulse consumes one expected event.
  initial begin
    logic [2:0] prev;
    ev_t g;
    ev_t e;
    wait (mon_en);
    @(negedge bclk);
    prev = bus.current_state;
    forever begin
      @(negedge bclk);
      if (bus.current_state !== prev || bus.tx_start === 1'b1) begin
        g = {bus.tx_start, bus.current_state, bus.matrix_size, bus.rx_enable, bus.mult_start,
             bus.read_enable_a, bus.read_enable_b, bus.tx_busy};
        prev = bus.current_state;
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got %0h expected none", g);
        end else begin
          e = expq.pop_front();
          check("event", int'(g), int'(e));
        end
      end
    end
  end

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'd0;
    bus.mult_done = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    check("reset_state", int'(bus.current_state), 0);
    check("reset_size", int'(bus.matrix_size), 0);
    check("reset_rx_enable", int'(bus.rx_enable), 0);
    check("reset_tx_start", int'(bus.tx_start), 0);
    check("reset_mult_start", int'(bus.mult_start), 0);
    check("reset_read_en", int'({bus.read_enable_a, bus.read_enable_b}), 0);
    expq.push_back(mk(1'b0, 3'd1, 0));
    mon_en = 1'b1;
    rst    = 1'b0;
    tick();
    check("post_reset_state", int'(bus.current_state), 1);
    check("post_reset_rx_enable", int'(bus.rx_enable), 1);

    run_txn(2, 1'b0, 1'b0);
    run_txn(1, 1'b1, 1'b0);
    run_txn(3, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      run_txn(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0);

    // Abort a full-size load partway through matrix B.
    send_size_and_a(10);
    for (int i = 0; i < 37; i++) begin
      gap();
      send_byte(8'($urandom_range(0, 255)));
    end
    check("abort_in_b", int'(bus.current_state), 3);
    expq.push_back(mk(1'b0, 3'd0, 0));
    expq.push_back(mk(1'b0, 3'd1, 0));
    rst = 1'b1;
    repeat (2) tick();
    check("abort_state", int'(bus.current_state), 0);
    check("abort_size", int'(bus.matrix_size), 0);
    rst = 1'b0;
    tick();
    check("abort_restart", int'(bus.current_state), 1);
    run_txn(3, 1'b0, 1'b0);

    repeat (20) tick();
    check("queue_drained", expq.size(), 0);
    summary_and_finish();
  end

endmodule
